// File: rtl/count_down_32_pkg.sv
// Shared core definitions for the loadable down-counter and the
// multdiv control that drives it.
package count_down_32_pkg;

    localparam int CNT_WIDTH     = 5;
    localparam int MULTDIV_ITERS = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cd_state_e;

    // IDLE and DONE both accept a new start (DONE gives back-to-back runs).
    function automatic logic is_accepting(input cd_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/count_down_32_if.sv
// Start/busy/done handshake bundle between multdiv control (master)
// and the down-counter (slave).
interface count_down_32_if
    import count_down_32_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             stall;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             last;

    modport master (
        output start,
        output load_val,
        output stall,
        output abort,
        input  count,
        input  busy,
        input  done,
        input  last
    );

    modport slave (
        input  start,
        input  load_val,
        input  stall,
        input  abort,
        output count,
        output busy,
        output done,
        output last
    );

endinterface

// File: rtl/count_down_32_down_reg.sv
// WIDTH-bit register with synchronous clear, load and saturating
// decrement; priority clear > load > dec.
module down_reg #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Decrement stops at zero: the count never wraps to all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_dec && (r_q != '0)) begin
            r_q <= r_q - WIDTH'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/count_down_32.sv
// Loadable down-counter with start/busy/done handshake, stall and
// abort; terminates multi-cycle multdiv operations.
module count_down_32
    import count_down_32_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic           i_clock,
    input  logic           i_reset,
    count_down_32_if.slave bus
);

    cd_state_e        r_state;
    cd_state_e        w_state_nxt;
    logic [WIDTH-1:0] w_count;
    logic             w_accept;
    logic             w_is_one;
    logic             w_clr_n;
    logic             w_load;
    logic             w_dec;

    assign w_accept = is_accepting(r_state) && bus.start;
    assign w_is_one = (w_count == WIDTH'(1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
            w_state_nxt = (bus.load_val == '0) ? ST_DONE : ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.abort) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.stall) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_count <= WIDTH'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Abort reuses the register clear so the count returns to zero.
    always_comb begin
        w_clr_n  = i_reset;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        bus.count = w_count;
        bus.busy  = (r_state == ST_RUN);
        bus.done  = (r_state == ST_DONE);
        bus.last  = (r_state == ST_RUN) && w_is_one;
        unique case (r_state)
            ST_RUN: begin
                if (bus.abort) begin
                    w_clr_n = 1'b0;
                end else if (!bus.stall) begin
                    w_dec = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                w_load = bus.start;
            end
            default: begin
                w_clr_n = 1'b0;
            end
        endcase
    end

    down_reg #(
        .WIDTH (WIDTH)
    ) u_down_reg (
        .i_clk   (i_clock),
        .i_clr_n (w_clr_n),
        .i_load  (w_load),
        .i_d     (bus.load_val),
        .i_dec   (w_dec),
        .o_q     (w_count)
    );

endmodule

// File: tb/tb_count_down_32.sv
// Self-checking bench for count_down_32: directed scenarios plus
// randomized traffic against a behavioural countdown model.
module tb_count_down_32;
    import count_down_32_pkg::*;

    localparam int W = CNT_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_cnt;
    bit m_run;
    bit m_done;

    count_down_32_if #(.WIDTH(W)) bus ();

    count_down_32 #(
        .WIDTH (W)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [W-1:0] n,
                         input logic stl, input logic ab);
        bus.start    = st;
        bus.load_val = n;
        bus.stall    = stl;
        bus.abort    = ab;
    endtask

    // Model: m_run = counting, m_done = completion pulse this cycle.
    task automatic model_step(input bit r, input bit st, input int n,
                              input bit stl, input bit ab);
        if (!r) begin
            m_cnt = 0; m_run = 0; m_done = 0;
        end else if (m_run) begin
            if (ab) begin
                m_run = 0; m_cnt = 0;
            end else if (!stl) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_run = 0; m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (st) begin
                m_cnt = n;
                if (n == 0) m_done = 1;
                else m_run = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, W'(9), 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.last} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL reset: c=%0d b=%b d=%b l=%b, want all 0",
                     bus.count, bus.busy, bus.done, bus.last);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] ec;
        int nbusy = 0;
        drive(1'b1, W'(5), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            drive(1'b0, '0, 1'b0, 1'b0);
            ec = W'(5 - i);
            if (bus.busy) nbusy++;
            checks++;
            if ({bus.count, bus.busy, bus.done, bus.last} !==
                {ec, ec != 0, ec == 0, ec == 1}) begin
                errors++;
                $display("FAIL basic[%0d]: c=%0d b=%b d=%b l=%b, want c=%0d",
                         i, bus.count, bus.busy, bus.done, bus.last, ec);
            end
        end
        tick();
        checks++;
        if (nbusy != 5 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: busy_cycles=%0d d=%b b=%b, want 5 0 0",
                     nbusy, bus.done, bus.busy);
        end
    endtask

    task automatic test_zero();
        drive(1'b1, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.last} !== {W'(0), 3'b010}) begin
            errors++;
            $display("FAIL zero_done: c=%0d b=%b d=%b l=%b, want 0 0 1 0",
                     bus.count, bus.busy, bus.done, bus.last);
        end
        tick();
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.last} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL zero_idle: c=%0d b=%b d=%b, want 0 0 0",
                     bus.count, bus.busy, bus.done);
        end
    endtask

    task automatic test_stall();
        int exp_c [8] = '{4, 3, 2, 2, 2, 2, 1, 0};
        logic [W-1:0] ec;
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, W'(4), (i >= 3 && i <= 5), 1'b0);
            tick();
            ec = W'(exp_c[i]);
            checks++;
            if ({bus.count, bus.busy, bus.done, bus.last} !==
                {ec, i != 7, i == 7, ec == 1}) begin
                errors++;
                $display("FAIL stall[%0d]: c=%0d b=%b d=%b l=%b, want c=%0d d=%b",
                         i, bus.count, bus.busy, bus.done, bus.last, ec, i == 7);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_abort();
        logic [W-1:0] ec;
        for (int i = 0; i < 22; i++) begin
            drive(i == 0, W'(MULTDIV_ITERS), 1'b0, 1'b0);
            tick();
            ec = W'(31 - i);
            checks++;
            if (bus.count !== ec || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL abort_run[%0d]: c=%0d d=%b b=%b, want c=%0d",
                         i, bus.count, bus.done, bus.busy, ec);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.count, bus.busy, bus.done} !== {W'(0), 2'b00}) begin
                errors++;
                $display("FAIL abort_after[%0d]: c=%0d b=%b d=%b, want 0 0 0",
                         i, bus.count, bus.busy, bus.done);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic st_v [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        int   ld_v [8] = '{3, 0, 0, 0, 2, 7, 0, 0};
        int   c_v  [8] = '{3, 2, 1, 0, 2, 1, 0, 0};
        logic b_v  [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
        logic d_v  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            drive(st_v[i], W'(ld_v[i]), 1'b0, 1'b0);
            tick();
            checks++;
            if (bus.count !== W'(c_v[i]) || bus.busy !== b_v[i] ||
                bus.done !== d_v[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: c=%0d b=%b d=%b, want c=%0d b=%b d=%b",
                         i, bus.count, bus.busy, bus.done, c_v[i], b_v[i], d_v[i]);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, W'(10), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.count !== W'(7) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_rst: c=%0d b=%b, want c=7 b=1",
                     bus.count, bus.busy);
        end
        rst_n = 1'b0;
        drive(1'b1, W'(20), 1'b0, 1'b0);
        tick();
        checks++;
        if ({bus.count, bus.busy, bus.done, bus.last} !== {W'(0), 3'b000}) begin
            errors++;
            $display("FAIL mid_rst: c=%0d b=%b d=%b l=%b, want all 0",
                     bus.count, bus.busy, bus.done, bus.last);
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        bit r, st, stl, ab;
        int n;
        model_step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 59) != 0);
            st  = ($urandom_range(0, 3) == 0);
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31)
                                               : $urandom_range(0, 5);
            stl = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 15) == 0);
            rst_n = r;
            drive(st, W'(n), stl, ab);
            model_step(r, st, n, stl, ab);
            tick();
            checks++;
            if (bus.count !== W'(m_cnt) || bus.busy !== m_run ||
                bus.done !== m_done || bus.last !== (m_run && m_cnt == 1)) begin
                errors++;
                $display("FAIL rand[%0d]: c=%0d b=%b d=%b l=%b, want c=%0d b=%b d=%b",
                         i, bus.count, bus.busy, bus.done, bus.last,
                         m_cnt, m_run, m_done);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
